pwr_switch_ctrl: RTL

//  Power-domain responder for the exec-unit power management unit.

---
 rtl/pwr_switch_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/pwr_switch_ctrl.sv
// pwr_switch_ctrl: staged header-switch sequencer for the exec-unit power domain.
// Define PSW_RETENTION_EN to add the ret_save/ret_restore retention handshake.
module pwr_switch_ctrl #(
   parameter int N_SWITCH  = 4,
   parameter int STAGE_DLY = 2,
   parameter int RST_HOLD  = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                pwr_down,
   input  logic                iso_enable,
   input  logic                pwron_reset,
   output logic [N_SWITCH-1:0] sw_en,
   output logic                pwr_good,
   output logic                iso_clamp,
   output logic                dom_rst,
   output logic [2:0]          pwr_state,
`ifdef PSW_RETENTION_EN
   output logic                ret_save,
   output logic                ret_restore,
`endif
   output logic                err_protocol
);

   typedef enum logic [2:0] {
      S_ON      = 3'd0,
      S_RAMP_DN = 3'd1,
      S_OFF     = 3'd2,
      S_RAMP_UP = 3'd3,
      S_HOLD    = 3'd4,
      S_SAVE    = 3'd5,
      S_RESTORE = 3'd6
   } state_t;

   localparam logic [N_SWITCH-1:0] SW_ALL = '1;
   localparam logic [N_SWITCH-1:0] SW_ONE = N_SWITCH'(1);
   localparam logic [3:0] STG_LAST = 4'(STAGE_DLY - 1);
   localparam logic [3:0] HLD_LAST = 4'(RST_HOLD - 1);

   state_t              state;
   logic [3:0]          stg_cnt;
   logic [3:0]          hld_cnt;
   logic [N_SWITCH-1:0] sw_dn;
   logic [N_SWITCH-1:0] sw_up;
   logic                stg_done;
   logic                hld_done;
   logic                req_dn;

   assign sw_dn     = sw_en >> 1;
   assign sw_up     = {sw_en[N_SWITCH-2:0], 1'b1};
   assign stg_done  = (stg_cnt >= STG_LAST);
   assign hld_done  = (hld_cnt >= HLD_LAST);
   assign req_dn    = pwr_down & iso_enable;
   assign pwr_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_HOLD;
         sw_en        <= SW_ALL;
         pwr_good     <= 1'b1;
         iso_clamp    <= 1'b1;
         dom_rst      <= 1'b1;
         err_protocol <= 1'b0;
         stg_cnt      <= '0;
         hld_cnt      <= '0;
`ifdef PSW_RETENTION_EN
         ret_save     <= 1'b0;
         ret_restore  <= 1'b0;
`endif
      end else begin
         // clamp stays on unless the branch below lands in ON
         iso_clamp <= 1'b1;
`ifdef PSW_RETENTION_EN
         ret_save    <= 1'b0;
         ret_restore <= 1'b0;
`endif
         if (pwr_down && !iso_enable) begin
            err_protocol <= 1'b1;
         end

         case (state)
            S_ON: begin
               sw_en    <= SW_ALL;
               pwr_good <= 1'b1;
               stg_cnt  <= '0;
               if (req_dn) begin
`ifdef PSW_RETENTION_EN
                  state    <= S_SAVE;
                  ret_save <= 1'b1;
                  dom_rst  <= dom_rst | pwron_reset;
`else
                  state    <= S_RAMP_DN;
                  sw_en    <= sw_dn;
                  pwr_good <= 1'b0;
                  dom_rst  <= 1'b1;
`endif
                  hld_cnt  <= '0;
               end else begin
                  iso_clamp <= iso_enable;
                  if (pwron_reset) begin
                     dom_rst <= 1'b1;
                     hld_cnt <= '0;
                  end else if (dom_rst) begin
                     if (hld_done) begin
                        dom_rst <= 1'b0;
                     end else begin
                        hld_cnt <= hld_cnt + 4'd1;
                     end
                  end
               end
            end

`ifdef PSW_RETENTION_EN
            S_SAVE: begin
               state    <= S_RAMP_DN;
               sw_en    <= sw_dn;
               pwr_good <= 1'b0;
               dom_rst  <= 1'b1;
               stg_cnt  <= '0;
               hld_cnt  <= '0;
            end

            S_RESTORE: begin
               state     <= S_ON;
               sw_en     <= SW_ALL;
               pwr_good  <= 1'b1;
               stg_cnt   <= '0;
               iso_clamp <= iso_enable;
               if (pwron_reset) begin
                  dom_rst <= 1'b1;
                  hld_cnt <= '0;
               end else begin
                  dom_rst <= 1'b0;
               end
            end
`endif

            S_RAMP_DN: begin
               pwr_good <= 1'b0;
               dom_rst  <= 1'b1;
               hld_cnt  <= '0;
               if (stg_done) begin
                  stg_cnt <= '0;
                  sw_en   <= sw_dn;
                  if (sw_dn == '0) begin
                     state <= S_OFF;
                  end
               end else begin
                  stg_cnt <= stg_cnt + 4'd1;
               end
            end

            S_OFF: begin
               sw_en    <= '0;
               pwr_good <= 1'b0;
               dom_rst  <= 1'b1;
               stg_cnt  <= '0;
               hld_cnt  <= '0;
               if (!pwr_down) begin
                  state <= S_RAMP_UP;
                  sw_en <= SW_ONE;
               end
            end

            S_RAMP_UP: begin
               pwr_good <= 1'b0;
               dom_rst  <= 1'b1;
               hld_cnt  <= '0;
               if (pwr_down) begin
                  // abort keeps the segments already on; first drop after a full stage
                  state   <= S_RAMP_DN;
                  stg_cnt <= '0;
               end else if (stg_done) begin
                  stg_cnt <= '0;
                  if (&sw_en) begin
                     state    <= S_HOLD;
                     pwr_good <= 1'b1;
                  end else begin
                     sw_en <= sw_up;
                  end
               end else begin
                  stg_cnt <= stg_cnt + 4'd1;
               end
            end

            S_HOLD: begin
               sw_en    <= SW_ALL;
               pwr_good <= 1'b1;
               dom_rst  <= 1'b1;
               stg_cnt  <= '0;
               if (pwr_down) begin
                  state    <= S_RAMP_DN;
                  sw_en    <= sw_dn;
                  pwr_good <= 1'b0;
                  hld_cnt  <= '0;
               end else if (pwron_reset) begin
                  hld_cnt <= '0;
               end else if (hld_done) begin
                  hld_cnt <= '0;
                  dom_rst <= 1'b0;
`ifdef PSW_RETENTION_EN
                  state       <= S_RESTORE;
                  ret_restore <= 1'b1;
`else
                  state     <= S_ON;
                  iso_clamp <= iso_enable;
`endif
               end else begin
                  hld_cnt <= hld_cnt + 4'd1;
               end
            end

            default: begin
               state    <= S_OFF;
               sw_en    <= '0;
               pwr_good <= 1'b0;
               dom_rst  <= 1'b1;
               stg_cnt  <= '0;
               hld_cnt  <= '0;
            end
         endcase
      end
   end

endmodule
